alu_issue_queue: RTL

Buffering stage directly upstream of the 32-bit combinational ALU (ports A, B, ALUControl, Z). It accepts ALU commands over a valid/ready handshake and holds them in a small FIFO. It presents the FIFO head to the ALU, then captures the ALU result in an output register with its own valid/ready handshake. The ALU command path is thereby decoupled from both the producer and the result consumer.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu.sv | 32 +++
 rtl/sync_fifo.sv | 53 +++++
 rtl/alu_issue_queue.sv | 99 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue queue: ALUControl codes,
// command layout and default sizes.
package alu_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int WIDTH_DEF = 32;
  localparam int TAG_W_DEF = 4;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_ANDN = 3'b100;
  localparam logic [2:0] ALU_ORN  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef struct packed {
    logic [2:0]           ctrl;
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
    logic [TAG_W_DEF-1:0] tag;
  } alu_cmd_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: Z = f(A, B) selected by ALUControl. Code 3'b011 yields 0.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Z
);

  logic [WIDTH-1:0] diff;

  assign diff = A - B;

  always_comb begin
    Z = '0;
    case (ALUControl)
      ALU_AND:  Z = A & B;
      ALU_OR:   Z = A | B;
      ALU_ADD:  Z = A + B;
      ALU_ANDN: Z = A & ~B;
      ALU_ORN:  Z = A | ~B;
      ALU_SUB:  Z = diff;
      // Signed compare: overflow-corrected sign of A - B.
      ALU_SLT:  Z = {{(WIDTH-1){1'b0}}, (A[WIDTH-1] ^ B[WIDTH-1]) ? A[WIDTH-1] : diff[WIDTH-1]};
      default:  Z = '0;
    endcase
  end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count. The read port is combinational and
// reads zero while empty. Push is ignored when full, pop when empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue queue in front of the combinational ALU: buffers tagged commands,
// feeds the head to the ALU and registers the result for a downstream consumer.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_ctrl,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_ctrl,
  input  logic [WIDTH-1:0]         alu_z,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_z,
  output logic                     res_zero,
  output logic [TAG_W-1:0]         res_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int EW = 3 + 2 * WIDTH + TAG_W;

  typedef struct packed {
    logic [2:0]       ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           wr_entry;
  entry_t           head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [TAG_W-1:0] tag_cnt;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready depends only on occupancy (no same-cycle pop bypass); the
  // producer must hold its command until accepted. res_valid stays high and
  // res_* stay stable until the consumer takes them with res_ready.
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!res_valid || res_ready);

  assign wr_entry = '{ctrl: in_ctrl, a: in_a, b: in_b, tag: tag_cnt};

  sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign alu_a    = head.a;
  assign alu_b    = head.b;
  assign alu_ctrl = head.ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_cnt <= '0;
    end else if (push) begin
      tag_cnt <= tag_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_z     <= '0;
      res_zero  <= 1'b0;
      res_tag   <= '0;
    end else if (pop) begin
      res_valid <= 1'b1;
      res_z     <= alu_z;
      res_zero  <= (alu_z == '0);
      res_tag   <= head.tag;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
